generic_reservation_station: RTL
================================

Name: generic_reservation_station

Overview:
- Parametrised, out-of-order reservation station for any functional unit (ALU, mult, div, branch).
- Sits between rename/dispatch and one execution unit.
- Holds DEPTH renamed instructions and snoops NUM_CDB common data buses for source wakeup.
- Issues the oldest ready entry through a registered valid/ready output stage that stalls on downstream back-pressure.

Parameters:
- DEPTH, 8, number of entries; power of two, 2..32.
- NUM_CDB, 2, number of CDB broadcast ports snooped per cycle.
- PREG_W, 6, physical register index width.
- ORDER_W, 64, instruction order tag width; the tag wraps.
- PAYLOAD_W, 128, opaque per-instruction payload (opcode, imm, rob idx, rvfi data); carried unmodified.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict flush; clears all state
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_ps1  in  PREG_W  source 1 physical register
- disp_ps1_v  in  1  source 1 already ready
- disp_ps2  in  PREG_W  source 2 physical register
- disp_ps2_v  in  1  source 2 already ready
- disp_order  in  ORDER_W  program-order tag
- disp_payload  in  PAYLOAD_W  opaque payload
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_pd  in  NUM_CDB*PREG_W  per-port destination preg; port k occupies bits [k*PREG_W +: PREG_W]
- iss_valid  out  1  issue register holds an instruction
- iss_ready  in  1  execution unit accepts
- iss_ps1, iss_ps2  out  PREG_W each  issued sources
- iss_order  out  ORDER_W  issued order tag
- iss_payload  out  PAYLOAD_W  issued payload
- occupancy  out  $clog2(DEPTH)+1  number of valid entries, excluding the issue register

Behaviour:
- Reset (rst=1 at a posedge): all entry valid bits = 0, iss_valid = 0, all iss_* data = 0, occupancy = 0, disp_ready = 1. rst has priority over every other input.
- Flush: same clearing effect as reset, applied the same cycle; flush overrides a simultaneous dispatch, wakeup and issue. The next cycle is empty.
- Dispatch:
  - disp_ready = !(all entries valid). It is computed from current state only; a slot freed by issue this cycle is not reusable until next cycle.
  - On disp_valid && disp_ready, the lowest-index free entry is written.
  - disp_valid while !disp_ready is ignored and nothing is written.
- Source readiness:
  - A source with preg 0 is forced ready at dispatch.
  - Entry srcN_v is set when any cdb_valid[k] has cdb_pd[k] == srcN and cdb_pd[k] != 0.
  - Wakeup applies to resident entries and also to the entry being dispatched in the same cycle (same-cycle bypass): a dispatched source whose preg is broadcast that cycle lands as ready.
  - All NUM_CDB ports are checked independently. Duplicate matches across ports are harmless.
- Eligibility: entry valid && src1_v && src2_v. Wakeups take effect from the next cycle; no combinational CDB-to-issue path.
- Select:
  - Among eligible entries, choose the oldest by wrap-aware compare: a is older than b iff (a - b) truncated to ORDER_W has MSB = 1.
  - Tags in flight are unique and span less than 2^(ORDER_W-1).
  - Implement as a DEPTH-wide pairwise compare tree.
- Issue register:
  - Loads when (!iss_valid || iss_ready) and some entry is eligible. The selected entry is cleared on the same edge and iss_valid = 1.
  - If iss_valid && iss_ready and nothing is eligible, iss_valid goes to 0 and data holds.
  - If iss_valid && !iss_ready, the issue register and all entries hold (stall).
  - Throughput: 1 issue/cycle.
- Latency: dispatch with both sources ready at edge N -> iss_valid at edge N+1 when the station is empty and not stalled. A CDB wakeup at edge N makes the entry issuable at edge N+1.
- occupancy: tracks valid entries after each edge (+1 on dispatch, -1 on select, net 0 when both happen). It never exceeds DEPTH.
- No X outputs under any state; the select has no don't-care output when no entry is eligible.

Test Plan:
- Reset/empty: assert rst 2 cycles -> iss_valid=0, occupancy=0, disp_ready=1. With DEPTH=8, dispatch 8 entries with ps1_v=ps2_v=0 -> disp_ready=0, occupancy=8; a 9th disp_valid is dropped.
- Oldest-first with wrap (ORDER_W=8): dispatch orders 0xFE, 0x01, 0xFF, all not ready; one cycle broadcast all sources -> issue sequence 0xFE, 0xFF, 0x01 on consecutive cycles with iss_ready=1.
- Same-cycle bypass: dispatch ps1=5 (v=0), ps2=0, while cdb_valid[1]=1 and cdb_pd[1]=5 -> iss_valid=1 the next cycle. Broadcast of pd=0 with ps1=0 pending changes nothing.
- Back-pressure: 3 ready entries, iss_ready=0 for 4 cycles -> iss_order stable, occupancy=2. Then iss_ready=1 -> remaining two issue on the next two cycles and iss_valid falls after the last.
- Flush mid-operation: 5 entries plus valid issue register, with flush coinciding with dispatch and CDB -> next cycle occupancy=0, iss_valid=0, disp_ready=1.
- Multi-CDB: NUM_CDB=2, entry waiting on ps1=7 and ps2=9; cdb_pd={9,7} both valid in one cycle -> entry issues at the following edge.

Source files
------------

// File: rtl/generic_reservation_station_if.sv
// Dispatch, CDB snoop and issue signals of a reservation station, bundled with
// master (rename/dispatch + execution side) and slave (station side) modports.
interface generic_reservation_station_if #(
  parameter int DEPTH     = 8,
  parameter int NUM_CDB   = 2,
  parameter int PREG_W    = 6,
  parameter int ORDER_W   = 64,
  parameter int PAYLOAD_W = 128
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid never depends combinationally on ready, and an offered
  // issue transfer holds its data stable until it is accepted.
  logic                         disp_valid;
  logic                         disp_ready;
  logic [PREG_W-1:0]            disp_ps1;
  logic                         disp_ps1_v;
  logic [PREG_W-1:0]            disp_ps2;
  logic                         disp_ps2_v;
  logic [ORDER_W-1:0]           disp_order;
  logic [PAYLOAD_W-1:0]         disp_payload;

  logic [NUM_CDB-1:0]           cdb_valid;
  logic [NUM_CDB*PREG_W-1:0]    cdb_pd;

  logic                         iss_valid;
  logic                         iss_ready;
  logic [PREG_W-1:0]            iss_ps1;
  logic [PREG_W-1:0]            iss_ps2;
  logic [ORDER_W-1:0]           iss_order;
  logic [PAYLOAD_W-1:0]         iss_payload;

  logic [OCC_W-1:0]             occupancy;

  modport master (
    output disp_valid, disp_ps1, disp_ps1_v, disp_ps2, disp_ps2_v, disp_order, disp_payload,
    output cdb_valid, cdb_pd, iss_ready,
    input  disp_ready, iss_valid, iss_ps1, iss_ps2, iss_order, iss_payload, occupancy
  );

  modport slave (
    input  disp_valid, disp_ps1, disp_ps1_v, disp_ps2, disp_ps2_v, disp_order, disp_payload,
    input  cdb_valid, cdb_pd, iss_ready,
    output disp_ready, iss_valid, iss_ps1, iss_ps2, iss_order, iss_payload, occupancy
  );
endinterface

// File: rtl/generic_reservation_station.sv
// Out-of-order reservation station: holds renamed instructions, wakes sources
// from the CDBs and issues the oldest ready entry through a registered stage.
module generic_reservation_station #(
  parameter int DEPTH     = 8,
  parameter int NUM_CDB   = 2,
  parameter int PREG_W    = 6,
  parameter int ORDER_W   = 64,
  parameter int PAYLOAD_W = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  generic_reservation_station_if.slave rs
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]     ent_v_q, ent_v_d;
  logic [DEPTH-1:0]     s1v_q, s1v_d;
  logic [DEPTH-1:0]     s2v_q, s2v_d;
  logic [PREG_W-1:0]    s1_q [DEPTH];
  logic [PREG_W-1:0]    s1_d [DEPTH];
  logic [PREG_W-1:0]    s2_q [DEPTH];
  logic [PREG_W-1:0]    s2_d [DEPTH];
  logic [ORDER_W-1:0]   ord_q [DEPTH];
  logic [ORDER_W-1:0]   ord_d [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d [DEPTH];

  logic                 iss_valid_q, iss_valid_d;
  logic [PREG_W-1:0]    iss_ps1_q, iss_ps1_d;
  logic [PREG_W-1:0]    iss_ps2_q, iss_ps2_d;
  logic [ORDER_W-1:0]   iss_order_q, iss_order_d;
  logic [PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
  logic [OCC_W-1:0]     occ_q, occ_d;

  logic [DEPTH-1:0]         elig;
  logic                     any_elig;
  logic [DEPTH*ORDER_W-1:0] ord_flat;
  logic [IDX_W-1:0]         sel_idx;
  logic [IDX_W-1:0]         free_idx;
  logic                     disp_fire;
  logic                     load;

  // preg 0 is the hard-wired zero register and never counts as a broadcast match.
  function automatic logic cdb_hit(input logic [PREG_W-1:0] p,
                                   input logic [NUM_CDB-1:0] v,
                                   input logic [NUM_CDB*PREG_W-1:0] pd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (v[k] && (pd[k*PREG_W +: PREG_W] == p) && (p != '0)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic older(input logic [ORDER_W-1:0] a, input logic [ORDER_W-1:0] b);
    logic [ORDER_W-1:0] diff;
    diff = a - b;
    return diff[ORDER_W-1];
  endfunction

  // Binary tournament: leaves at DEPTH..2*DEPTH-1, root at node 1. With no
  // eligible leaf the winner is a defined index whose result is never used.
  function automatic logic [IDX_W-1:0] pick_oldest(input logic [DEPTH-1:0] el,
                                                   input logic [DEPTH*ORDER_W-1:0] ords);
    logic               nv [2*DEPTH];
    logic [IDX_W-1:0]   ni [2*DEPTH];
    logic [ORDER_W-1:0] no [2*DEPTH];
    logic               take_b;
    nv[0] = 1'b0;
    ni[0] = '0;
    no[0] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      nv[DEPTH+i] = el[i];
      ni[DEPTH+i] = i[IDX_W-1:0];
      no[DEPTH+i] = ords[i*ORDER_W +: ORDER_W];
    end
    for (int n = DEPTH - 1; n >= 1; n--) begin
      take_b = nv[2*n+1] && (!nv[2*n] || older(no[2*n+1], no[2*n]));
      nv[n]  = nv[2*n] || nv[2*n+1];
      ni[n]  = take_b ? ni[2*n+1] : ni[2*n];
      no[n]  = take_b ? no[2*n+1] : no[2*n];
    end
    return ni[1];
  endfunction

  always_comb begin
    ord_flat = '0;
    for (int i = 0; i < DEPTH; i++) ord_flat[i*ORDER_W +: ORDER_W] = ord_q[i];
  end

  assign elig     = ent_v_q & s1v_q & s2v_q;
  assign any_elig = |elig;
  assign sel_idx  = pick_oldest(elig, ord_flat);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_v_q[i]) free_idx = i[IDX_W-1:0];
    end
  end

  // Dispatch only sees slots free before this edge; an issuing slot reopens next cycle.
  assign disp_fire = rs.disp_valid && !(&ent_v_q);
  assign load      = (!iss_valid_q || rs.iss_ready) && any_elig;

  always_comb begin
    ent_v_d       = ent_v_q;
    s1v_d         = s1v_q;
    s2v_d         = s2v_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    ord_d         = ord_q;
    pay_d         = pay_q;
    iss_valid_d   = iss_valid_q;
    iss_ps1_d     = iss_ps1_q;
    iss_ps2_d     = iss_ps2_q;
    iss_order_d   = iss_order_q;
    iss_payload_d = iss_payload_q;
    occ_d         = occ_q + OCC_W'(disp_fire) - OCC_W'(load);

    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_hit(s1_q[i], rs.cdb_valid, rs.cdb_pd)) s1v_d[i] = 1'b1;
      if (cdb_hit(s2_q[i], rs.cdb_valid, rs.cdb_pd)) s2v_d[i] = 1'b1;
    end

    if (load) begin
      ent_v_d[sel_idx] = 1'b0;
      iss_valid_d      = 1'b1;
      iss_ps1_d        = s1_q[sel_idx];
      iss_ps2_d        = s2_q[sel_idx];
      iss_order_d      = ord_q[sel_idx];
      iss_payload_d    = pay_q[sel_idx];
    end else if (iss_valid_q && rs.iss_ready) begin
      iss_valid_d = 1'b0;
    end

    if (disp_fire) begin
      ent_v_d[free_idx] = 1'b1;
      s1_d[free_idx]    = rs.disp_ps1;
      s2_d[free_idx]    = rs.disp_ps2;
      s1v_d[free_idx]   = rs.disp_ps1_v || (rs.disp_ps1 == '0) ||
                          cdb_hit(rs.disp_ps1, rs.cdb_valid, rs.cdb_pd);
      s2v_d[free_idx]   = rs.disp_ps2_v || (rs.disp_ps2 == '0) ||
                          cdb_hit(rs.disp_ps2, rs.cdb_valid, rs.cdb_pd);
      ord_d[free_idx]   = rs.disp_order;
      pay_d[free_idx]   = rs.disp_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_v_q <= '0;
      s1v_q   <= '0;
      s2v_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        s1_q[i]  <= '0;
        s2_q[i]  <= '0;
        ord_q[i] <= '0;
        pay_q[i] <= '0;
      end
      iss_valid_q   <= 1'b0;
      iss_ps1_q     <= '0;
      iss_ps2_q     <= '0;
      iss_order_q   <= '0;
      iss_payload_q <= '0;
      occ_q         <= '0;
    end else begin
      ent_v_q       <= ent_v_d;
      s1v_q         <= s1v_d;
      s2v_q         <= s2v_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      ord_q         <= ord_d;
      pay_q         <= pay_d;
      iss_valid_q   <= iss_valid_d;
      iss_ps1_q     <= iss_ps1_d;
      iss_ps2_q     <= iss_ps2_d;
      iss_order_q   <= iss_order_d;
      iss_payload_q <= iss_payload_d;
      occ_q         <= occ_d;
    end
  end

  assign rs.disp_ready  = !(&ent_v_q);
  assign rs.iss_valid   = iss_valid_q;
  assign rs.iss_ps1     = iss_ps1_q;
  assign rs.iss_ps2     = iss_ps2_q;
  assign rs.iss_order   = iss_order_q;
  assign rs.iss_payload = iss_payload_q;
  assign rs.occupancy   = occ_q;
endmodule
